// File: rtl/ext_obi_xbar.sv
`default_nettype none
// ============================================================================
// ext_obi_xbar : N-master / M-slave OBI crossbar with per-slave round-robin,
//                in-order response routing and a built-in decode-error responder
// Revision     : 1.0
// ============================================================================
module ext_obi_xbar #(
  parameter int                   NMASTER         = 9,
  parameter int                   NSLAVE          = 2,
  parameter int                   MAX_OUTSTANDING = 4,
  parameter logic [NSLAVE*32-1:0] SLV_START_ADDR  = {32'hF010_0000, 32'hF000_0000},
  parameter logic [NSLAVE*32-1:0] SLV_END_ADDR    = {32'hF020_0000, 32'hF010_0000}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NMASTER-1:0]    m_req_i,
  output logic [NMASTER-1:0]    m_gnt_o,
  input  logic [NMASTER*32-1:0] m_addr_i,
  input  logic [NMASTER-1:0]    m_we_i,
  input  logic [NMASTER*4-1:0]  m_be_i,
  input  logic [NMASTER*32-1:0] m_wdata_i,
  output logic [NMASTER-1:0]    m_rvalid_o,
  output logic [NMASTER*32-1:0] m_rdata_o,
  output logic [NMASTER-1:0]    m_err_o,
  output logic [NSLAVE-1:0]     s_req_o,
  input  logic [NSLAVE-1:0]     s_gnt_i,
  output logic [NSLAVE*32-1:0]  s_addr_o,
  output logic [NSLAVE-1:0]     s_we_o,
  output logic [NSLAVE*4-1:0]   s_be_o,
  output logic [NSLAVE*32-1:0]  s_wdata_o,
  input  logic [NSLAVE-1:0]     s_rvalid_i,
  input  logic [NSLAVE*32-1:0]  s_rdata_i,
  output logic                  proto_err_o
);

  localparam int IDW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
  localparam int TW  = $clog2(NSLAVE + 1);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [TW-1:0] ERR_TGT = TW'(NSLAVE);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [TW-1:0]      w_tgt    [NMASTER];
  logic [NMASTER-1:0] w_elig, w_hs, w_rsp;
  logic [CW-1:0]      cnt_q    [NMASTER];
  logic [CW-1:0]      cnt_d    [NMASTER];
  logic [TW-1:0]      ltgt_q   [NMASTER];
  logic [NMASTER-1:0] errv_q;

  logic [NMASTER-1:0] w_cand   [NSLAVE];
  logic [IDW-1:0]     w_win    [NSLAVE];
  logic [NSLAVE-1:0]  w_hs_s, w_pop, w_full, w_empty;
  logic [IDW-1:0]     rr_q     [NSLAVE];
  logic [IDW-1:0]     lock_id_q[NSLAVE];
  logic [NSLAVE-1:0]  lock_q;
  logic [IDW-1:0]     fifo_q   [NSLAVE][MAX_OUTSTANDING];
  logic [PW-1:0]      wr_q     [NSLAVE];
  logic [PW-1:0]      rd_q     [NSLAVE];
  logic [CW-1:0]      fcnt_q   [NSLAVE];
  logic [CW-1:0]      fcnt_d   [NSLAVE];
  logic               proto_q;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] ptr, input int k);
    int v;
    v = int'(ptr) + k;
    if (v >= NMASTER) v = v - NMASTER;
    return IDW'(v);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Decode walks downwards so the lowest matching window wins on overlap.
  always_comb begin
    for (int m = 0; m < NMASTER; m++) begin
      w_tgt[m] = ERR_TGT;
      for (int s = NSLAVE - 1; s >= 0; s--) begin
        if ((m_addr_i[m*32 +: 32] >= SLV_START_ADDR[s*32 +: 32]) &&
            (m_addr_i[m*32 +: 32] <  SLV_END_ADDR[s*32 +: 32]))
          w_tgt[m] = TW'(s);
      end
      w_elig[m] = m_req_i[m] && (cnt_q[m] < MAX_CNT) &&
                  ((cnt_q[m] == '0) || (w_tgt[m] == ltgt_q[m]));
    end
  end

  always_comb begin
    s_req_o   = '0;
    s_addr_o  = '0;
    s_we_o    = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    for (int s = 0; s < NSLAVE; s++) begin
      w_full[s]  = (fcnt_q[s] == MAX_CNT);
      w_empty[s] = (fcnt_q[s] == '0);
      w_cand[s]  = '0;
      for (int m = 0; m < NMASTER; m++)
        w_cand[s][m] = w_elig[m] && (w_tgt[m] == TW'(s));
      w_win[s] = '0;
      for (int k = NMASTER - 1; k >= 0; k--) begin
        if (w_cand[s][rr_idx(rr_q[s], k)]) w_win[s] = rr_idx(rr_q[s], k);
      end
      // A request left ungranted keeps its winner until the slave accepts it.
      if (lock_q[s] && w_cand[s][lock_id_q[s]]) w_win[s] = lock_id_q[s];
      s_req_o[s] = !w_full[s] && (|w_cand[s]);
      if (s_req_o[s]) begin
        s_addr_o[s*32 +: 32]  = m_addr_i[int'(w_win[s])*32 +: 32];
        s_wdata_o[s*32 +: 32] = m_wdata_i[int'(w_win[s])*32 +: 32];
        s_be_o[s*4 +: 4]      = m_be_i[int'(w_win[s])*4 +: 4];
        s_we_o[s]             = m_we_i[w_win[s]];
      end
      w_hs_s[s] = s_req_o[s] && s_gnt_i[s];
      w_pop[s]  = s_rvalid_i[s] && !w_empty[s];
      fcnt_d[s] = fcnt_q[s] + CW'(w_hs_s[s]) - CW'(w_pop[s]);
    end
  end

  always_comb begin
    m_rdata_o = '0;
    for (int m = 0; m < NMASTER; m++) begin
      w_hs[m]  = w_elig[m] && (w_tgt[m] == ERR_TGT);
      w_rsp[m] = errv_q[m];
      for (int s = 0; s < NSLAVE; s++) begin
        if (w_hs_s[s] && (w_win[s] == IDW'(m))) w_hs[m] = 1'b1;
        if (w_pop[s] && (fifo_q[s][rd_q[s]] == IDW'(m))) begin
          w_rsp[m]              = 1'b1;
          m_rdata_o[m*32 +: 32] = s_rdata_i[s*32 +: 32];
        end
      end
      cnt_d[m] = cnt_q[m] + CW'(w_hs[m]) - CW'(w_rsp[m]);
    end
  end

  assign m_gnt_o     = w_hs;
  assign m_rvalid_o  = w_rsp;
  assign m_err_o     = errv_q;
  assign proto_err_o = proto_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < NSLAVE; s++) begin
        for (int d = 0; d < MAX_OUTSTANDING; d++) fifo_q[s][d] <= '0;
        wr_q[s]      <= '0;
        rd_q[s]      <= '0;
        fcnt_q[s]    <= '0;
        rr_q[s]      <= '0;
        lock_id_q[s] <= '0;
      end
      lock_q  <= '0;
      proto_q <= 1'b0;
    end else begin
      for (int s = 0; s < NSLAVE; s++) begin
        if (w_hs_s[s]) begin
          fifo_q[s][wr_q[s]] <= w_win[s];
          wr_q[s]            <= ptr_inc(wr_q[s]);
          rr_q[s]            <= (w_win[s] == IDW'(NMASTER - 1)) ? '0 : w_win[s] + 1'b1;
        end
        if (w_pop[s]) rd_q[s] <= ptr_inc(rd_q[s]);
        fcnt_q[s]    <= fcnt_d[s];
        lock_q[s]    <= s_req_o[s] && !s_gnt_i[s];
        lock_id_q[s] <= w_win[s];
        if (s_rvalid_i[s] && w_empty[s]) proto_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int m = 0; m < NMASTER; m++) begin
        cnt_q[m]  <= '0;
        ltgt_q[m] <= '0;
      end
      errv_q <= '0;
    end else begin
      for (int m = 0; m < NMASTER; m++) begin
        cnt_q[m] <= cnt_d[m];
        if (w_hs[m]) ltgt_q[m] <= w_tgt[m];
        errv_q[m] <= w_hs[m] && (w_tgt[m] == ERR_TGT);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ext_obi_xbar.md
Name: ext_obi_xbar

Overview:
- Parametrised N-master to M-slave OBI crossbar for the external SoC bus. It replaces the fixed 9-master / 1-slave external crossbar mapping.
- Each slave window is decoded from per-slave start/end address parameters. Every slave has its own round-robin arbiter.
- Each slave keeps an in-order response-routing FIFO that records which master issued each accepted request.
- Addresses outside every window are accepted and answered with an error response, so no master can hang on a bad access.

Parameters:
- NMASTER, 9, number of master ports.
- NSLAVE, 2, number of slave ports.
- MAX_OUTSTANDING, 4, routing-FIFO depth per slave and outstanding limit per master (power of 2, >=1).
- SLV_START_ADDR, {32'hF010_0000, 32'hF000_0000}, packed NSLAVE*32 start addresses; slave i uses bits [32i+31:32i].
- SLV_END_ADDR, {32'hF020_0000, 32'hF010_0000}, packed NSLAVE*32 end addresses (exclusive).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- m_req_i  in  NMASTER  master request
- m_gnt_o  out  NMASTER  master grant
- m_addr_i  in  NMASTER*32  master address
- m_we_i  in  NMASTER  write enable
- m_be_i  in  NMASTER*4  byte enables
- m_wdata_i  in  NMASTER*32  write data
- m_rvalid_o  out  NMASTER  response valid
- m_rdata_o  out  NMASTER*32  read data
- m_err_o  out  NMASTER  decode error, qualified by m_rvalid_o
- s_req_o  out  NSLAVE  slave request
- s_gnt_i  in  NSLAVE  slave grant
- s_addr_o, s_wdata_o  out  NSLAVE*32  forwarded address / write data
- s_we_o  out  NSLAVE  forwarded write enable
- s_be_o  out  NSLAVE*4  forwarded byte enables
- s_rvalid_i  in  NSLAVE  slave response valid
- s_rdata_i  in  NSLAVE*32  slave read data
- proto_err_o  out  1  sticky flag: a slave returned rvalid with nothing outstanding

Behaviour:
- **Decode:** target = lowest i with SLV_START_ADDR[i] <= addr < SLV_END_ADDR[i]. If no window matches, target = ERR (internal index NSLAVE). Overlapping windows resolve to the lower index.
- **Per-master state:** outstanding count cnt (0..MAX_OUTSTANDING) and last target ltgt.
  - Master is eligible iff m_req_i=1, cnt<MAX_OUTSTANDING, and (cnt==0 or target==ltgt).
  - The same-target rule keeps a master's responses in order and guarantees at most one response source per master per cycle.
- **Slave arbitration (combinational request, registered pointer):**
  - Candidates are eligible masters targeting slave j.
  - If the slave-j FIFO is not full and at least one candidate exists: s_req_o[j]=1. The winner is the first candidate at or after rr_ptr[j] (cyclic). The winner's addr/we/be/wdata are muxed onto slave j.
  - m_gnt_o[winner] = s_gnt_i[j].
  - When s_gnt_i[j] is not asserted, the winner's payload is held and the arbiter does not re-arbitrate, so s_req_o stays stable until grant.
  - On handshake (s_req_o[j] & s_gnt_i[j]): push the winner ID, set rr_ptr[j] = winner+1 mod NMASTER, increment the winner's cnt, set ltgt = j.
  - With no request, s_addr_o/s_we_o/s_be_o/s_wdata_o are 0.
- **Slave response:** s_rvalid_i[j] with FIFO j non-empty pops the head ID h in the same cycle and drives m_rvalid_o[h]=1, m_rdata_o[h]=s_rdata_i[j], m_err_o[h]=0, decrements cnt[h]. Zero added latency.
- **Orphan response:** s_rvalid_i[j] with FIFO j empty is dropped and sets proto_err_o=1 until reset.
- **Simultaneous push/pop** on a FIFO: both happen; occupancy is unchanged. A full FIFO with a pop in the same cycle still blocks the push (s_req_o computed on the registered full flag).
- **ERR target:**
  - An eligible master targeting ERR gets m_gnt_o=1 in the same cycle (all ERR requesters granted in parallel). Its cnt increments and ltgt=ERR.
  - Next cycle: m_rvalid_o=1, m_rdata_o=32'h0, m_err_o=1, cnt decrements.
  - Back-to-back ERR requests give one response per cycle.
- **cnt update:** grant and response to the same master in one cycle leave cnt unchanged.
- **Reset (asynchronous, also mid-transaction):**
  - FIFOs emptied, cnt=0, ltgt=0, rr_ptr=0, ERR response registers=0, proto_err_o=0.
  - m_rvalid_o=0 and m_err_o=0 while rst_i=1.
  - In-flight transactions are abandoned. Late slave responses after reset are orphan responses (dropped, proto_err_o set).

Test Plan:
- **Single access:** master 0 reads 0xF000_0010; slave 0 grants at once and returns rvalid 2 cycles later with 32'hCAFE_0001 -> m_gnt_o[0] in the request cycle; m_rvalid_o[0]=1, m_rdata_o=CAFE_0001, m_err_o=0 in the same cycle as s_rvalid_i[0].
- **Round-robin:** masters 0, 3, 8 request slave 1 continuously, s_gnt_i=1 -> grant order 0, 3, 8, 0, 3, 8.
- **Per-master outstanding limit:** master 2 issues 5 writes to slave 0 with rvalid held low -> 4 grants, 5th stalled. One rvalid -> 5th granted the next cycle.
- **Same-target rule:** master 1 has a pending access to slave 0, then requests 0xF010_0000 (slave 1) -> no grant until the slave-0 response returns; slave 1 is granted afterwards.
- **Decode error:** master 5 accesses 0x1000_0000 -> m_gnt_o[5]=1 same cycle, next cycle m_rvalid_o[5]=1, m_err_o=1, m_rdata_o=0. No s_req_o asserted.
- **Reset mid-flight:** 2 transactions outstanding on slave 0, pulse rst_i, then s_rvalid_i[0] arrives -> no m_rvalid_o, proto_err_o=1; cnt=0 so any target is immediately eligible.
